// File: rtl/pipe_pkg.sv
// Shared pipeline types: writeback source select, load funct3 codes, WB FSM states.
package pipe_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Extracts and extends a byte/halfword/word from a load response word.
module load_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);
  import pipe_pkg::*;

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = rdata_i[{addr_i, 3'b000} +: 8];
    // Halfword lane uses addr[1] only; misaligned addr[0] is ignored.
    half_w = rdata_i[{addr_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
      F3_LH:   data_o = {{(XLEN-16){half_w[15]}}, half_w};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_w};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_w};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: EX->WB register, source mux, load wait/timeout FSM,
// register-file write port (also the decode bypass) and retired counter.
module wb_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_rf_en,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_wb_sel,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_csr_rdata,
  input  logic             flush_i,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             rf_en,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  wdata,
  output logic             stall_o,
  output logic             load_err,
  output logic [CNT_W-1:0] instret_o
);
  import pipe_pkg::*;

  localparam int unsigned CW = $clog2(LOAD_TIMEOUT + 1);

  logic             v_q;
  logic             rfen_q;
  logic [4:0]       rd_q;
  wb_sel_e          sel_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  csr_q;

  wb_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] instret_q;

  logic             is_load;
  logic             timeout;
  logic             done;
  logic             stall;
  logic [XLEN-1:0]  ld_data;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata_i  (dmem_rdata),
    .addr_i   (alu_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    is_load = (sel_q == WB_LOAD);
    timeout = (state_q == WAIT) && (cnt_q == CW'(LOAD_TIMEOUT));
    done    = v_q && (!is_load || dmem_rvalid || timeout);
    stall   = v_q && is_load && !done;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (v_q && is_load && !dmem_rvalid) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle takes priority over the error.
        if (dmem_rvalid) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = RUN;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= 1'b0;
      rfen_q    <= 1'b0;
      rd_q      <= '0;
      sel_q     <= WB_ALU;
      f3_q      <= '0;
      alu_q     <= '0;
      pc_q      <= '0;
      csr_q     <= '0;
      state_q   <= RUN;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      if (!stall) begin
        v_q    <= ex_valid & ~flush_i;
        rfen_q <= ex_rf_en;
        rd_q   <= ex_rd;
        sel_q  <= wb_sel_e'(ex_wb_sel);
        f3_q   <= ex_funct3;
        alu_q  <= ex_alu_result;
        pc_q   <= ex_pc;
        csr_q  <= ex_csr_rdata;
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (done) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rf_en = done && rfen_q && (rd_q != '0);
    rd    = rd_q;
    case (sel_q)
      WB_LOAD: wdata = (timeout && !dmem_rvalid) ? '0 : ld_data;
      WB_PC4:  wdata = pc_q + XLEN'(4);
      WB_CSR:  wdata = csr_q;
      default: wdata = alu_q;
    endcase
  end

  assign stall_o   = stall;
  assign load_err  = err_q;
  assign instret_o = instret_q;

endmodule
